// File: rtl/la_pkg.sv
// la_pkg: shared state codes and constants for the logic-analyzer capture sequencer.
package la_pkg;
    localparam int STATE_W = 5;
    localparam logic [7:0] LA_HEADER_BYTE = 8'hA5;
    typedef enum logic [2:0] {
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_HEADER  = 3'd3,
        ST_RD_REQ  = 3'd4,
        ST_RD_WAIT = 3'd5,
        ST_SEND    = 3'd6,
        ST_DONE    = 3'd7
    } state_e;
endpackage

// File: rtl/la_capture_sequencer_if.sv
// la_capture_sequencer_if: sample RAM port and UART TX valid/ready byte stream.
interface la_capture_sequencer_if #(
    parameter int DATA_W = 3,
    parameter int ADDR_W = 8
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    modport master (output mem_we, mem_addr, mem_wdata, tx_data, tx_valid, input mem_rdata, tx_ready);
    modport slave  (input mem_we, mem_addr, mem_wdata, tx_data, tx_valid, output mem_rdata, tx_ready);
endinterface

// File: rtl/la_sample_tick.sv
// la_sample_tick: free-running divider, one-clock tick every SAMPLE_DIV clocks.
module la_sample_tick #(
    parameter int SAMPLE_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);
    localparam int CW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick_o = cnt_q == CW'(SAMPLE_DIV - 1);
    assign cnt_d  = tick_o ? '0 : cnt_q + CW'(1);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/la_capture_sequencer.sv
// la_capture_sequencer: trigger, capture DEPTH samples to RAM, then dump header + samples over UART TX.
module la_capture_sequencer
    import la_pkg::*;
#(
    parameter int         DATA_W      = 3,
    parameter int         ADDR_W      = 8,
    parameter int         SAMPLE_DIV  = 16,
    parameter logic [7:0] HEADER_BYTE = LA_HEADER_BYTE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    sample_in,
    input  logic [DATA_W-1:0]    trig_mask,
    input  logic                 arm,
    la_capture_sequencer_if.master bus,
    output logic                 done,
    output logic [STATE_W-1:0]   state_debug
);
    localparam logic [ADDR_W-1:0] LAST = '1;
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] prev_q, prev_d, mem_wdata_q, mem_wdata_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              mem_we_q, mem_we_d, tick, trig, tx_valid, hs;
    la_sample_tick #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (.clk(clk), .rst(rst), .tick_o(tick));
    assign trig     = ((sample_in ^ prev_q) & trig_mask) != '0 || trig_mask == '0;
    assign tx_valid = state_q == ST_HEADER || state_q == ST_SEND;
    assign hs       = tx_valid && bus.tx_ready;
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        prev_d      = tick ? sample_in : prev_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tx_data_d   = tx_data_q;
        case (state_q)
            ST_ARMED: if (tick && trig) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = '0;
                mem_wdata_d = sample_in;
                wr_ptr_d    = ADDR_W'(1);
                state_d     = ST_CAPTURE;
            end
            ST_CAPTURE: if (tick) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = wr_ptr_q;
                mem_wdata_d = sample_in;
                wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
                tx_data_d   = wr_ptr_q == LAST ? HEADER_BYTE : tx_data_q;
                state_d     = wr_ptr_q == LAST ? ST_HEADER : ST_CAPTURE;
            end
            ST_HEADER: if (hs) begin
                rd_ptr_d   = '0;
                mem_addr_d = '0;
                state_d    = ST_RD_REQ;
            end
            ST_RD_REQ: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                tx_data_d = 8'(mem_rdata_zx(bus.mem_rdata));
                state_d   = ST_SEND;
            end
            // mem_addr follows rd_ptr so the RAM sees the address during RD_REQ
            ST_SEND: if (hs) begin
                rd_ptr_d   = rd_ptr_q == LAST ? rd_ptr_q : rd_ptr_q + ADDR_W'(1);
                mem_addr_d = rd_ptr_d;
                state_d    = rd_ptr_q == LAST ? ST_DONE : ST_RD_REQ;
            end
            ST_DONE: state_d = arm ? ST_ARMED : ST_DONE;
            default: state_d = ST_ARMED;
        endcase
    end
    function automatic logic [7:0] mem_rdata_zx(input logic [DATA_W-1:0] d);
        return 8'(d);
    endfunction
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q     <= ST_ARMED;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            prev_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            prev_q      <= prev_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tx_data_q   <= tx_data_d;
        end
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid;
    assign done          = state_q == ST_DONE;
    assign state_debug   = STATE_W'(state_q);
endmodule

// File: tb/tb_la_capture_sequencer.sv
// tb_la_capture_sequencer: directed capture/dump scenarios with write and byte scoreboards.
module tb_la_capture_sequencer;
    typedef struct packed {logic [2:0] addr; logic [2:0] data;} wr_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] sample_in = 3'd0;
    logic [2:0] trig_mask = 3'b111;
    logic       arm = 1'b0;
    logic       done;
    logic [4:0] state_debug;
    logic [2:0] ram [8];
    int         passed = 0, total = 0, cyc = 0, last_wr = 0;
    wr_t        wr_q [$];
    logic [7:0] tx_q [$];
    wr_t        we_exp;
    logic [7:0] tx_exp;
    la_capture_sequencer_if #(.DATA_W(3), .ADDR_W(3)) bus ();
    la_capture_sequencer #(.DATA_W(3), .ADDR_W(3), .SAMPLE_DIV(4), .HEADER_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .trig_mask(trig_mask), .arm(arm),
        .bus(bus), .done(done), .state_debug(state_debug)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask
    // Monitor: pops expected RAM writes and TX bytes as the DUT presents them
    always @(negedge clk) begin
        cyc++;
        if (!rst && bus.mem_we) begin
            if (wr_q.size() == 0) check("unexpected_write", 1, 0);
            else begin
                we_exp = wr_q.pop_front();
                check("wr_addr", bus.mem_addr, we_exp.addr);
                check("wr_data", bus.mem_wdata, we_exp.data);
                if (we_exp.addr != 3'd0) check("wr_spacing", cyc - last_wr, 4);
                last_wr = cyc;
            end
        end
        if (!rst && bus.tx_valid && bus.tx_ready) begin
            if (tx_q.size() == 0) check("unexpected_byte", 1, 0);
            else begin
                tx_exp = tx_q.pop_front();
                check("tx_byte", bus.tx_data, tx_exp);
            end
        end
    end
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic wait_we();
        int n = 0;
        do begin step(1); n++; end while (!bus.mem_we && n < 50);
        if (!bus.mem_we) check("write_timeout", 0, 1);
    endtask
    task automatic wait_state(input logic [4:0] st);
        int n = 0;
        while (state_debug != st && n < 300) begin step(1); n++; end
        check("wait_state", state_debug, st);
    endtask
    task automatic capture(input logic [7:0][2:0] s);
        tx_q.push_back(8'hA5);
        for (int i = 0; i < 8; i++) begin
            wr_q.push_back('{addr: 3'(i), data: s[i]});
            tx_q.push_back({5'b0, s[i]});
        end
        sample_in = s[0];
        for (int i = 1; i < 8; i++) begin
            wait_we();
            sample_in = s[i];
        end
    endtask
    task automatic wait_done();
        int n = 0;
        while (!done && n < 300) begin step(1); n++; end
        check("done", done, 1);
        check("state_done", state_debug, 5'd7);
        check("tx_drained", tx_q.size(), 0);
        check("wr_drained", wr_q.size(), 0);
    endtask
    task automatic rearm();
        arm = 1'b1;
        step(1);
        arm = 1'b0;
        check("rearm_state", state_debug, 5'd1);
        check("rearm_done", done, 0);
    endtask
    initial begin
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("rst_state", state_debug, 5'd1);
            check("rst_tx_valid", bus.tx_valid, 0);
            check("rst_mem_we", bus.mem_we, 0);
            check("rst_done", done, 0);
            check("rst_mem_addr", bus.mem_addr, 0);
        end
        rst = 1'b0;
        capture({3'd7, 3'd6, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1});
        wait_done();
        trig_mask = 3'b100;
        rearm();
        sample_in = 3'd6;
        step(8);
        check("mask_bit0_armed", state_debug, 5'd1);
        sample_in = 3'd7;
        step(8);
        check("mask_bit0_armed2", state_debug, 5'd1);
        capture({3'd3, 3'd0, 3'd6, 3'd5, 3'd4, 3'd2, 3'd1, 3'd3});
        wait_state(5'd6);
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("stall_valid", bus.tx_valid, 1);
            check("stall_data", bus.tx_data, 8'h03);
        end
        bus.tx_ready = 1'b1;
        wait_done();
        trig_mask = 3'b111;
        rearm();
        capture({3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4, 3'd7, 3'd5});
        wait_state(5'd6);
        rst = 1'b1;
        #1;
        check("midrst_tx_valid", bus.tx_valid, 0);
        check("midrst_state", state_debug, 5'd1);
        check("midrst_mem_we", bus.mem_we, 0);
        wr_q.delete();
        tx_q.delete();
        sample_in = 3'd0;
        step(2);
        rst = 1'b0;
        capture({3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd2});
        wait_done();
        rearm();
        capture({3'd5, 3'd5, 3'd2, 3'd2, 3'd7, 3'd0, 3'd1, 3'd6});
        wait_done();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
